mem_port_arbiter: RTL

Two-requester arbiter and sequencer for the single-port 32-bit word-addressed memory used by the RISC-V datapath. It shares one memory port (addr, Din, we, re, out) between the instruction-fetch unit and the load/store unit using round-robin arbitration. It inserts a programmable number of wait cycles and returns read data through a registered req/ack handshake. Out-of-range addresses are rejected with an error flag and never reach the memory.

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer that shares one single-port word memory
// between instruction fetch and load/store, with programmable wait cycles.
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter int WAIT_CYCLES = 0,
  parameter int MEM_SIZE    = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic       GNT_IF    = 1'b0;
  localparam logic       GNT_D     = 1'b1;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_last_gnt;
  logic        r_gnt;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_din;
  logic        r_mem_we;
  logic        r_mem_re;
  logic        r_if_ack;
  logic        r_if_err;
  logic [31:0] r_if_rdata;
  logic        r_d_ack;
  logic        r_d_err;
  logic [31:0] r_d_rdata;

  logic        w_any_req;
  logic        w_pick_d;
  logic [31:0] w_addr;
  logic        w_we;
  logic        w_err;
  logic        w_final;
  logic [31:0] w_rdata;

  // Data wins when it is alone, or on a tie when fetch was served last.
  assign w_any_req = if_req | d_req;
  assign w_pick_d  = d_req & (~if_req | (r_last_gnt == GNT_IF));
  assign w_addr    = w_pick_d ? d_addr : if_addr;
  assign w_we      = w_pick_d & d_we;
  assign w_err     = (w_addr >= 32'(MEM_SIZE));
  assign w_final   = (r_cnt == 4'd0);
  assign w_rdata   = (r_err || r_we) ? 32'h0 : mem_out;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the async reset clears outputs (mem_we included)
  // the moment rst rises, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_last_gnt <= GNT_D;
      r_gnt      <= GNT_IF;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_mem_addr <= 32'h0;
      r_mem_din  <= 32'h0;
      r_mem_we   <= 1'b0;
      r_mem_re   <= 1'b0;
      r_if_ack   <= 1'b0;
      r_if_err   <= 1'b0;
      r_if_rdata <= 32'h0;
      r_d_ack    <= 1'b0;
      r_d_err    <= 1'b0;
      r_d_rdata  <= 32'h0;
    end else begin
      r_if_ack <= 1'b0;
      r_if_err <= 1'b0;
      r_d_ack  <= 1'b0;
      r_d_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_gnt      <= w_pick_d;
            r_last_gnt <= w_pick_d;
            r_we       <= w_we;
            r_err      <= w_err;
            r_cnt      <= WAIT_LOAD;
            r_mem_addr <= w_err ? 32'h0 : w_addr;
            r_mem_din  <= (!w_err && w_we) ? d_wdata : 32'h0;
            r_mem_re   <= !w_err && !w_we;
            r_mem_we   <= !w_err && w_we && (WAIT_LOAD == 4'd0);
            r_state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (!w_final) begin
            r_cnt    <= r_cnt - 4'd1;
            // The single write lands in the last ACCESS cycle only.
            r_mem_we <= r_we && !r_err && (r_cnt == 4'd1);
          end else begin
            r_mem_addr <= 32'h0;
            r_mem_din  <= 32'h0;
            r_mem_we   <= 1'b0;
            r_mem_re   <= 1'b0;
            if (r_gnt == GNT_D) begin
              r_d_rdata <= w_rdata;
              r_d_ack   <= 1'b1;
              r_d_err   <= r_err;
            end else begin
              r_if_rdata <= w_rdata;
              r_if_ack   <= 1'b1;
              r_if_err   <= r_err;
            end
            r_state <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign mem_we   = r_mem_we;
  assign mem_re   = r_mem_re;
  assign if_ack   = r_if_ack;
  assign if_err   = r_if_err;
  assign if_rdata = r_if_rdata;
  assign d_ack    = r_d_ack;
  assign d_err    = r_d_err;
  assign d_rdata  = r_d_rdata;
  assign busy     = (r_state != IDLE);

endmodule
